// File: rtl/switch_debouncer.sv
// switch_debouncer: synchronises raw slide-switch levels into the clk domain,
// rejects contact bounce with a per-bit stability counter, and emits a clean
// switch vector plus registered one-cycle rise/fall/any_change pulses.
module switch_debouncer #(
  parameter int WIDTH         = 8,
  parameter int STABLE_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_change
);

  // Counter only needs to reach STABLE_CYCLES-1, which always fits in clog2 bits.
  localparam int             CNT_W   = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  // Per-channel state: derived from whether the synchronised level disagrees
  // with the debounced output, so no separate state flop is needed.
  localparam logic STABLE   = 1'b0;
  localparam logic SETTLING = 1'b1;

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] done;

  // Two-flop synchroniser; nothing may sit between s1 and s2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= sw_raw;
      s2 <= s1;
    end
  end

  // Decode channel state and detect the edge on which settling completes.
  always_comb begin
    state = '0;
    done  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      state[i] = (s2[i] != sw_db[i]) ? SETTLING : STABLE;
      done[i]  = (state[i] == SETTLING) && (cnt[i] == CNT_MAX);
    end
  end

  // Stability counters: run while settling, clear on bounce-back or completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (state[i] == STABLE || done[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debounced level: a bit adopts the synchronised value only on completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_db <= '0;
    end else begin
      sw_db <= (sw_db & ~done) | (s2 & done);
    end
  end

  // Edge pulses registered alongside the sw_db update, so they cover exactly
  // the cycle after it; polarity of the new level picks rise versus fall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rise       <= '0;
      fall       <= '0;
      any_change <= 1'b0;
    end else begin
      rise       <= done & s2;
      fall       <= done & ~s2;
      any_change <= |done;
    end
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench for switch_debouncer with STABLE_CYCLES=4, WIDTH=8.
// Stimulus drives sw_raw on falling edges and pushes the expected pulse event
// (the edge count at which it becomes visible plus sw_db/rise/fall); the
// monitor samples on falling edges and pops whenever any_change is high.
module tb_switch_debouncer;

  localparam int W  = 8;
  localparam int SC = 4;
  // Value driven at a falling edge is captured at the next rising edge k;
  // sw_db updates at k+SC+1 and the pulse is sampled at the falling edge
  // after that, when edge_n == (edge_n at drive) + SC + 2.
  localparam int LAT = SC + 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] sw_raw = '0;
  logic [W-1:0] sw_db;
  logic [W-1:0] rise;
  logic [W-1:0] fall;
  logic         any_change;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  typedef struct {
    int           edge_no;
    logic [W-1:0] db;
    logic [W-1:0] r;
    logic [W-1:0] f;
  } exp_t;

  exp_t q[$];

  switch_debouncer #(.WIDTH(W), .STABLE_CYCLES(SC)) dut (
    .clk        (clk),
    .reset      (reset),
    .sw_raw     (sw_raw),
    .sw_db      (sw_db),
    .rise       (rise),
    .fall       (fall),
    .any_change (any_change)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  // Monitor: pulse consistency every cycle, scoreboard pop on any_change.
  exp_t e;
  always @(negedge clk) begin
    checks++;
    if (any_change !== |(rise | fall)) begin
      errors++;
      $display("FAIL any_change_or edge=%0d actual=%b required=%b", edge_n, any_change, |(rise | fall));
    end
    checks++;
    if ((rise & fall) !== '0) begin
      errors++;
      $display("FAIL rise_fall_excl edge=%0d actual=%h required=00", edge_n, rise & fall);
    end
    if (any_change === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse edge=%0d actual db=%h rise=%h fall=%h required none",
                 edge_n, sw_db, rise, fall);
      end else begin
        e = q.pop_front();
        if (edge_n != e.edge_no || sw_db !== e.db || rise !== e.r || fall !== e.f) begin
          errors++;
          $display("FAIL pulse_event actual edge=%0d db=%h rise=%h fall=%h required edge=%0d db=%h rise=%h fall=%h",
                   edge_n, sw_db, rise, fall, e.edge_no, e.db, e.r, e.f);
        end
      end
    end else if (q.size() > 0 && edge_n >= q[0].edge_no) begin
      checks++;
      errors++;
      e = q.pop_front();
      $display("FAIL missing_pulse actual edge=%0d no pulse required edge=%0d db=%h rise=%h fall=%h",
               edge_n, e.edge_no, e.db, e.r, e.f);
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive a new level at the current falling edge and optionally queue its event.
  task automatic drive(input logic [W-1:0] v, input bit expect_ev,
                       input logic [W-1:0] db, input logic [W-1:0] r, input logic [W-1:0] f);
    exp_t x;
    sw_raw = v;
    if (expect_ev) begin
      x.edge_no = edge_n + LAT;
      x.db = db;
      x.r  = r;
      x.f  = f;
      q.push_back(x);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_db"},   sw_db, 8'h00);
    chk({name, "_rise"}, rise,  8'h00);
    chk({name, "_fall"}, fall,  8'h00);
    chk({name, "_any"},  {7'b0, any_change}, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog edge=%0d actual=running required=finished", edge_n);
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset, then hold zeros
    cycles(3);
    #1 chk_all_zero("reset_hold");
    @(negedge clk);
    reset = 1'b0;
    cycles(12);
    chk_all_zero("idle_zero");

    // 2: bit0 rises; then drop it again to exercise fall
    drive(8'h01, 1'b1, 8'h01, 8'h01, 8'h00);
    cycles(4);
    chk("bit0_not_yet", sw_db, 8'h00);
    cycles(8);
    chk("bit0_high", sw_db, 8'h01);
    drive(8'h00, 1'b1, 8'h00, 8'h00, 8'h01);
    cycles(12);
    chk("bit0_low", sw_db, 8'h00);

    // 3: bit3 bounce: high 2, low 1, high 2, then low steady
    drive(8'h08, 1'b0, '0, '0, '0); cycles(2);
    drive(8'h00, 1'b0, '0, '0, '0); cycles(1);
    drive(8'h08, 1'b0, '0, '0, '0); cycles(2);
    drive(8'h00, 1'b0, '0, '0, '0); cycles(12);
    chk("bounce_db", sw_db, 8'h00);

    // 4: bits 2 and 7 rise together, bit2 falls 10 cycles later
    drive(8'h84, 1'b1, 8'h84, 8'h84, 8'h00);
    cycles(10);
    drive(8'h80, 1'b1, 8'h80, 8'h00, 8'h04);
    cycles(12);
    chk("dual_end_db", sw_db, 8'h80);

    // 6: bit5 toggling every cycle for 50 cycles
    for (int i = 0; i < 50; i++) begin
      drive(sw_raw ^ 8'h20, 1'b0, '0, '0, '0);
      cycles(1);
    end
    drive(8'h80, 1'b0, '0, '0, '0);
    cycles(12);
    chk("toggle_db", sw_db, 8'h80);

    // 5: all high, reset mid-settle, release and hold
    drive(8'hFF, 1'b0, '0, '0, '0);
    cycles(3);
    reset = 1'b1;
    #1 chk_all_zero("mid_reset");
    cycles(2);
    chk_all_zero("mid_reset_late");
    // Released at a falling edge: the next rising edge recaptures 8'hFF.
    reset = 1'b0;
    drive(8'hFF, 1'b1, 8'hFF, 8'hFF, 8'h00);
    cycles(4);
    chk("post_reset_not_yet", sw_db, 8'h00);
    cycles(10);
    chk("post_reset_db", sw_db, 8'hFF);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d pending required=0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
